mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 32 +++
 rtl/mem_arbiter_arb_pick.sv | 45 ++++
 rtl/mem_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared core bus package: bus widths, request/response payloads and the
// arbiter state/owner encodings used by mem_arbiter and arb_pick.
package mem_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = DATA_W / 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } mem_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } mem_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Winner selection between IFU and LSU. Fixed LSU priority by default;
// with ARB_ROUND_ROBIN_EN defined, ties go to the master not picked last.
module arb_pick
  import mem_arbiter_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  logic   clk,
  input  logic   rst_n,
  input  logic   pick_en,
`endif
  input  logic   ifu_valid,
  input  logic   lsu_valid,
  output owner_e pick
);

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_q;

  // Only tie decisions move the pointer, so a lone request never steals a turn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= OWN_IFU;
    end else if (pick_en && ifu_valid && lsu_valid) begin
      last_q <= pick;
    end
  end

  always_comb begin
    pick = OWN_IFU;
    if (ifu_valid && lsu_valid) begin
      pick = (last_q == OWN_IFU) ? OWN_LSU : OWN_IFU;
    end else if (lsu_valid) begin
      pick = OWN_LSU;
    end
  end
`else
  always_comb begin
    pick = OWN_IFU;
    if (lsu_valid) begin
      pick = OWN_LSU;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (IFU/LSU) to one-slave memory arbiter, one transaction in flight.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin tie breaking.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ifu_req_valid,
  output logic       ifu_req_ready,
  input  mem_req_t   ifu_req,
  output logic       ifu_resp_valid,
  input  logic       ifu_resp_ready,
  output mem_resp_t  ifu_resp,
  input  logic       lsu_req_valid,
  output logic       lsu_req_ready,
  input  mem_req_t   lsu_req,
  output logic       lsu_resp_valid,
  input  logic       lsu_resp_ready,
  output mem_resp_t  lsu_resp,
  output logic       mem_req_valid,
  input  logic       mem_req_ready,
  output mem_req_t   mem_req,
  input  logic       mem_resp_valid,
  output logic       mem_resp_ready,
  input  mem_resp_t  mem_resp,
  output arb_state_e dbg_state,
  output owner_e     dbg_owner
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and payload is meaningful only while valid.

  arb_state_e state_q, state_d;
  owner_e     owner_q, owner_d;
  owner_e     pick;
  logic       own_req_valid;
  logic       own_resp_ready;

`ifdef ARB_ROUND_ROBIN_EN
  logic pick_en;
  assign pick_en = (state_q == ST_IDLE);
`endif

  arb_pick u_pick (
`ifdef ARB_ROUND_ROBIN_EN
    .clk       (clk),
    .rst_n     (rst_n),
    .pick_en   (pick_en),
`endif
    .ifu_valid (ifu_req_valid),
    .lsu_valid (lsu_req_valid),
    .pick      (pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IFU;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  assign own_req_valid  = (owner_q == OWN_LSU) ? lsu_req_valid  : ifu_req_valid;
  assign own_resp_ready = (owner_q == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;

  // Response data is broadcast; only the valid is steered to the owner.
  assign ifu_resp  = mem_resp;
  assign lsu_resp  = mem_resp;
  assign dbg_state = state_q;
  assign dbg_owner = owner_q;

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b0;
    mem_req        = (owner_q == OWN_LSU) ? lsu_req : ifu_req;
    if (owner_q == OWN_IFU) begin
      mem_req.wen = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (ifu_req_valid || lsu_req_valid) begin
          owner_d = pick;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req_valid = own_req_valid;
        if (owner_q == OWN_LSU) lsu_req_ready = mem_req_ready;
        else                    ifu_req_ready = mem_req_ready;
        // A withdrawn request is abandoned before it reaches the slave.
        if (!own_req_valid) begin
          state_d = ST_IDLE;
        end else if (mem_req_ready) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        mem_resp_ready = own_resp_ready;
        if (owner_q == OWN_LSU) lsu_resp_valid = mem_resp_valid;
        else                    ifu_resp_valid = mem_resp_valid;
        if (mem_resp_valid && own_resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
